// File: rtl/regbank_mp.sv
// rtl/regbank_mp.sv - multi-mode register bank with bypass, busy scoreboard and debug tap
module regbank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readAddA,
  output logic [DATA_W-1:0] readDataA,
  output logic              busyA,
  input  logic [ADDR_W-1:0] readAddB,
  output logic [DATA_W-1:0] readDataB,
  output logic              busyB,
  input  logic [1:0]        RegWrite,
  input  logic [ADDR_W-1:0] writeAdd,
  input  logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] highData,
  input  logic [DATA_W-1:0] raDataIn,
  output logic [DATA_W-1:0] raDataOut,
  input  logic              reserveEn,
  input  logic [ADDR_W-1:0] reserveAdd,
  input  logic [ADDR_W-1:0] dbgAdd,
  output logic [DATA_W-1:0] rOut,
  output logic              wrConflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] R0_A   = '0;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // Two write targets per edge; target 1 is applied last so it wins on a collision.
  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              we0, we1;

  logic [ADDR_W-1:0] rd_add  [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_add[0] = readAddA;
  assign rd_add[1] = readAddB;
  assign readDataA = rd_data[0];
  assign readDataB = rd_data[1];
  assign busyA     = rd_busy[0];
  assign busyB     = rd_busy[1];
  assign raDataOut = regs[LINK_A];

  // Decode the write mode into up to two targets, dropping any that land on a hardwired R0.
  always_comb begin
    wa0 = writeAdd;
    wd0 = writeData;
    we0 = 1'b0;
    wa1 = LINK_A;
    wd1 = raDataIn;
    we1 = 1'b0;
    case (RegWrite)
      2'd1: we0 = 1'b1;
      2'd2: begin
        wa0 = {writeAdd[ADDR_W-1:1], 1'b0};
        wa1 = {writeAdd[ADDR_W-1:1], 1'b1};
        wd1 = highData;
        we0 = 1'b1;
        we1 = 1'b1;
      end
      2'd3: begin
        we0 = 1'b1;
        we1 = 1'b1;
      end
      default: ;
    endcase
    if (ZERO_R0 != 0) begin
      if (wa0 == R0_A) we0 = 1'b0;
      if (wa1 == R0_A) we1 = 1'b0;
    end
  end

  // Read ports: array value, optionally overridden by the in-flight write, R0 forced to zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_add[p]];
      rd_busy[p] = busy[rd_add[p]];
      if (BYPASS != 0) begin
        if (we0 && wa0 == rd_add[p]) rd_data[p] = wd0;
        if (we1 && wa1 == rd_add[p]) rd_data[p] = wd1;
        if (((we0 && wa0 == rd_add[p]) || (we1 && wa1 == rd_add[p])) &&
            !(reserveEn && reserveAdd == rd_add[p]))
          rd_busy[p] = 1'b0;
      end
      if (ZERO_R0 != 0 && rd_add[p] == R0_A) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  // Scoreboard update: writes clear, a same-cycle reservation overrides the clear.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (reserveEn && !(ZERO_R0 != 0 && reserveAdd == R0_A))
      busy_nxt[reserveAdd] = 1'b1;
  end

  // Register array update; the link/high target is written last to take precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[wa0] <= wd0;
      if (we1) regs[wa1] <= wd1;
    end
  end

  // Busy bits, debug tap (pre-write array value) and collision pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      rOut       <= '0;
      wrConflict <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      rOut       <= regs[dbgAdd];
      wrConflict <= (RegWrite == 2'd3) && (writeAdd == LINK_A);
    end
  end

endmodule

// File: tb/tb_regbank_mp.sv
// tb/tb_regbank_mp.sv - self-checking bench for regbank_mp (bypass and non-bypass instances)
module tb_regbank_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  readAddA, readAddB, writeAdd, reserveAdd, dbgAdd;
  logic [1:0]  RegWrite;
  logic [31:0] writeData, highData, raDataIn;
  logic        reserveEn;

  logic [31:0] rd_a, rd_b, ra_out, r_out;
  logic [31:0] nb_rd_a, nb_rd_b, nb_ra_out, nb_r_out;
  logic        bz_a, bz_b, conf, nb_bz_a, nb_bz_b, nb_conf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regbank_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .readAddA(readAddA), .readDataA(rd_a), .busyA(bz_a),
    .readAddB(readAddB), .readDataB(rd_b), .busyB(bz_b),
    .RegWrite(RegWrite), .writeAdd(writeAdd), .writeData(writeData),
    .highData(highData), .raDataIn(raDataIn), .raDataOut(ra_out),
    .reserveEn(reserveEn), .reserveAdd(reserveAdd),
    .dbgAdd(dbgAdd), .rOut(r_out), .wrConflict(conf)
  );

  regbank_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .readAddA(readAddA), .readDataA(nb_rd_a), .busyA(nb_bz_a),
    .readAddB(readAddB), .readDataB(nb_rd_b), .busyB(nb_bz_b),
    .RegWrite(RegWrite), .writeAdd(writeAdd), .writeData(writeData),
    .highData(highData), .raDataIn(raDataIn), .raDataOut(nb_ra_out),
    .reserveEn(reserveEn), .reserveAdd(reserveAdd),
    .dbgAdd(dbgAdd), .rOut(nb_r_out), .wrConflict(nb_conf)
  );

  // Reference model: register contents, busy flags, and the list of writes in this cycle.
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  logic [31:0] mem [32];
  bit          busy_m [32];
  logic [31:0] rout_m;
  bit          conf_m;
  wr_t         wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    if (a != 0) begin
      w.a = a;
      w.d = d;
      wq.push_back(w);
    end
  endtask

  // Writes in order of application; a later entry overrides an earlier one.
  task automatic compute_writes();
    int lo;
    wq.delete();
    lo = int'(writeAdd) - (int'(writeAdd) % 2);
    case (RegWrite)
      2'd1: add_wr(writeAdd, writeData);
      2'd2: begin
        add_wr(5'(lo), writeData);
        add_wr(5'(lo + 1), highData);
      end
      2'd3: begin
        add_wr(writeAdd, writeData);
        add_wr(5'd31, raDataIn);
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'd0;
    v = mem[a];
    if (byp) foreach (wq[k]) if (wq[k].a == a) v = wq[k].d;
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    bit hit = 0;
    if (a == 0) return 1'b0;
    foreach (wq[k]) if (wq[k].a == a) hit = 1;
    if (byp && hit && !(reserveEn && reserveAdd == a)) return 1'b0;
    return busy_m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'd0;
      busy_m[i] = 0;
    end
    rout_m = 32'd0;
    conf_m = 0;
  endtask

  // One clock: check combinational outputs before the edge, advance the model, check registered outputs.
  task automatic step();
    #1;
    compute_writes();
    chk("rdA",     rd_a,      exp_read(readAddA, 1));
    chk("rdB",     rd_b,      exp_read(readAddB, 1));
    chk("busyA",   32'(bz_a), 32'(exp_busy(readAddA, 1)));
    chk("busyB",   32'(bz_b), 32'(exp_busy(readAddB, 1)));
    chk("nb_rdA",  nb_rd_a,   exp_read(readAddA, 0));
    chk("nb_busyB",32'(nb_bz_b), 32'(exp_busy(readAddB, 0)));
    chk("raOut",   ra_out,    mem[31]);
    @(posedge clk);
    rout_m = mem[dbgAdd];
    conf_m = (RegWrite == 2'd3) && (writeAdd == 5'd31);
    foreach (wq[k]) begin
      mem[wq[k].a] = wq[k].d;
      busy_m[wq[k].a] = 0;
    end
    if (reserveEn && reserveAdd != 0) busy_m[reserveAdd] = 1;
    #1;
    chk("rOut",       r_out,        rout_m);
    chk("wrConflict", 32'(conf),    32'(conf_m));
    chk("nb_rOut",    nb_r_out,     rout_m);
    @(negedge clk);
  endtask

  task automatic idle();
    RegWrite  = 2'd0;
    reserveEn = 1'b0;
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      RegWrite   = 2'($urandom_range(0, 3));
      writeAdd   = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      writeData  = $urandom;
      highData   = $urandom;
      raDataIn   = $urandom;
      reserveEn  = ($urandom_range(0, 2) == 0);
      reserveAdd = ($urandom_range(0, 2) == 0) ? writeAdd : 5'($urandom_range(0, 7));
      readAddA   = ($urandom_range(0, 2) == 0) ? writeAdd : 5'($urandom_range(0, 7));
      readAddB   = ($urandom_range(0, 2) == 0) ? (writeAdd | 5'd1) : 5'($urandom_range(0, 31));
      dbgAdd     = 5'($urandom_range(0, 7));
      step();
    end
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [4:0]  wa;
    logic [31:0] wd, hd, ra;
    logic        ren;
    logic [4:0]  radd, rda;
    logic [31:0] e_data;
    logic        e_busy;
    logic [31:0] e_raout;
    logic        e_conf;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{2'd1, 5'd8,  32'd18,        32'd0,         32'd0,     1'b0, 5'd0, 5'd8,  32'd18,        1'b0, 32'h0,   1'b0};
    tbl[1]  = '{2'd2, 5'd5,  32'hAAAA0001,  32'hBBBB0002,  32'd0,     1'b0, 5'd0, 5'd4,  32'hAAAA0001,  1'b0, 32'h0,   1'b0};
    tbl[2]  = '{2'd0, 5'd0,  32'd0,         32'd0,         32'd0,     1'b0, 5'd0, 5'd5,  32'hBBBB0002,  1'b0, 32'h0,   1'b0};
    tbl[3]  = '{2'd2, 5'd0,  32'h11111111,  32'hBBBB0002,  32'd0,     1'b0, 5'd0, 5'd0,  32'h0,         1'b0, 32'h0,   1'b0};
    tbl[4]  = '{2'd0, 5'd0,  32'd0,         32'd0,         32'd0,     1'b0, 5'd0, 5'd1,  32'hBBBB0002,  1'b0, 32'h0,   1'b0};
    tbl[5]  = '{2'd3, 5'd31, 32'd7,         32'd0,         32'h400,   1'b0, 5'd0, 5'd31, 32'h400,       1'b0, 32'h400, 1'b1};
    tbl[6]  = '{2'd0, 5'd0,  32'd0,         32'd0,         32'd0,     1'b0, 5'd0, 5'd31, 32'h400,       1'b0, 32'h400, 1'b0};
    tbl[7]  = '{2'd3, 5'd10, 32'h77,        32'd0,         32'h500,   1'b0, 5'd0, 5'd10, 32'h77,        1'b0, 32'h500, 1'b0};
    tbl[8]  = '{2'd0, 5'd0,  32'd0,         32'd0,         32'd0,     1'b1, 5'd6, 5'd6,  32'h0,         1'b1, 32'h500, 1'b0};
    tbl[9]  = '{2'd1, 5'd6,  32'h66,        32'd0,         32'd0,     1'b0, 5'd0, 5'd6,  32'h66,        1'b0, 32'h500, 1'b0};
    tbl[10] = '{2'd1, 5'd6,  32'h67,        32'd0,         32'd0,     1'b1, 5'd6, 5'd6,  32'h67,        1'b1, 32'h500, 1'b0};
    tbl[11] = '{2'd0, 5'd0,  32'd0,         32'd0,         32'd0,     1'b1, 5'd0, 5'd0,  32'h0,         1'b0, 32'h500, 1'b0};
    tbl[12] = '{2'd1, 5'd0,  32'h99,        32'd0,         32'd0,     1'b0, 5'd0, 5'd0,  32'h0,         1'b0, 32'h500, 1'b0};

    rst = 1'b0;
    readAddA = 5'd8; readAddB = 5'd31; writeAdd = 5'd0; reserveAdd = 5'd0; dbgAdd = 5'd0;
    writeData = 32'd0; highData = 32'd0; raDataIn = 32'd0;
    idle();
    model_reset();
    #1;
    chk("reset_rdA",  rd_a,          32'd0);
    chk("reset_rdB",  rd_b,          32'd0);
    chk("reset_ra",   ra_out,        32'd0);
    chk("reset_rOut", r_out,         32'd0);
    chk("reset_conf", 32'(conf),     32'd0);
    chk("reset_busy", 32'(bz_a),     32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      RegWrite = tbl[i].m;  writeAdd = tbl[i].wa; writeData = tbl[i].wd;
      highData = tbl[i].hd; raDataIn = tbl[i].ra; reserveEn = tbl[i].ren;
      reserveAdd = tbl[i].radd; readAddA = tbl[i].rda;
      step();
      idle();
      #1;
      chk($sformatf("tbl%0d_data", i),    rd_a,         tbl[i].e_data);
      chk($sformatf("tbl%0d_nbdata", i),  nb_rd_a,      tbl[i].e_data);
      chk($sformatf("tbl%0d_busy", i),    32'(bz_a),    32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_raout", i),   ra_out,       tbl[i].e_raout);
      chk($sformatf("tbl%0d_conf", i),    32'(conf),    32'(tbl[i].e_conf));
    end

    // Debug tap: one cycle after selecting R8 the tap shows 18.
    dbgAdd = 5'd8;
    step();
    chk("rout_r8", r_out, 32'd18);

    // Same-cycle forwarding versus the non-forwarding instance.
    RegWrite = 2'd1; writeAdd = 5'd3; writeData = 32'h55; readAddB = 5'd3;
    #1;
    chk("byp_same_cycle",   rd_b,    32'h55);
    chk("nobyp_old_value",  nb_rd_b, 32'h0);
    step();
    idle();
    #1;
    chk("nobyp_after_edge", nb_rd_b, 32'h55);

    rand_steps(300);

    // Async reset mid-sequence after a collision and a reservation.
    RegWrite = 2'd3; writeAdd = 5'd31; writeData = 32'd1; raDataIn = 32'h1234;
    reserveEn = 1'b1; reserveAdd = 5'd4; readAddA = 5'd31; readAddB = 5'd4; dbgAdd = 5'd31;
    step();
    idle();
    #1;
    chk("pre_reset_conf", 32'(conf), 32'd1);
    chk("pre_reset_busy", 32'(bz_b), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("areset_rdA",   rd_a,          32'd0);
    chk("areset_nbrdA", nb_rd_a,       32'd0);
    chk("areset_busyB", 32'(bz_b),     32'd0);
    chk("areset_nbbz",  32'(nb_bz_b),  32'd0);
    chk("areset_rOut",  r_out,         32'd0);
    chk("areset_ra",    ra_out,        32'd0);
    chk("areset_conf",  32'(conf),     32'd0);
    chk("areset_nbcf",  32'(nb_conf),  32'd0);

    // A write presented while reset is held is discarded.
    RegWrite = 2'd1; writeAdd = 5'd2; writeData = 32'hDEAD; readAddA = 5'd2;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    chk("reset_drop_wr",   rd_a,    32'd0);
    chk("reset_drop_nbwr", nb_rd_a, 32'd0);

    rand_steps(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
# regbank_mp

Parametrised multi-mode register bank, the successor to the fixed 32×32 register bank in the KGP-RISC datapath. It provides two combinational read ports with optional write-to-read bypass, and one write port with four modes: none, single, 64-bit pair (HI/LO), and single write plus link-register update. A per-register busy scoreboard supports hazard detection. A registered debug tap and a write-collision flag complete the block. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- LINK_REG, 31, index of the link (ra) register
- ZERO_R0, 1, when 1: R0 reads 0, ignores writes, is never busy
- BYPASS, 1, when 1: same-cycle write data is forwarded to the read ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- readAddA  in  ADDR_W  port A read address
- readDataA  out  DATA_W  port A read data
- busyA  out  1  port A register busy flag
- readAddB  in  ADDR_W  port B read address
- readDataB  out  DATA_W  port B read data
- busyB  out  1  port B register busy flag
- RegWrite  in  2  write mode: 0 none, 1 single, 2 pair, 3 single+link
- writeAdd  in  ADDR_W  write address (pair: base)
- writeData  in  DATA_W  write data (pair: low word)
- highData  in  DATA_W  pair high word
- raDataIn  in  DATA_W  link data (mode 3)
- raDataOut  out  DATA_W  current contents of LINK_REG
- reserveEn  in  1  set busy bit of reserveAdd
- reserveAdd  in  ADDR_W  register being reserved
- dbgAdd  in  ADDR_W  debug tap address
- rOut  out  DATA_W  registered contents of reg[dbgAdd]
- wrConflict  out  1  registered one-cycle pulse on a mode-3 collision

## Operation
- Mode 1: reg[writeAdd] <= writeData.
- Mode 2: low = {writeAdd[ADDR_W-1:1],0}, high = low|1. reg[low] <= writeData and reg[high] <= highData in the same edge; bit 0 of writeAdd is ignored.
- Mode 3: reg[writeAdd] <= writeData and reg[LINK_REG] <= raDataIn.
  - If writeAdd==LINK_REG, raDataIn wins and wrConflict=1 on the next cycle.
- ZERO_R0=1: any write targeting R0 is dropped; other targets in the same write still complete.
  - Example: mode 2, base 0 writes R1 only.
- Reads are combinational. The effective data is the array value, except:
  - With BYPASS=1 and an active write targeting the read address, the data is the value being written, using the same precedence as the array update.
  - R0 returns 0 when ZERO_R0=1.
- Scoreboard, one busy bit per register:
  - reserveEn sets busy[reserveAdd].
  - Any write that actually updates a register clears its bit.
  - Same-cycle reserve and write to the same register: reserve wins, bit ends set.
- busyX = busy[readAddX], forced 0 when:
  - BYPASS=1 and an un-reserved same-cycle write hits readAddX, or
  - readAddX is R0 with ZERO_R0=1.
- raDataOut = reg[LINK_REG], combinational from the array (not bypassed).
- rOut <= reg[dbgAdd] each edge, sampling the array before that edge's write.

## Timing
- Reset (rst=0, async): all registers 0, all busy bits 0, rOut=0, wrConflict=0; hence readDataA/B=0 and raDataOut=0. Reset asserted mid-write discards the write.
- First write is accepted on the first rising edge with rst=1.
- Write latency: array updated at the edge. Without bypass, a read sees the new value immediately after that edge; with bypass, it sees it in the same cycle.
- Reservation: busy visible immediately after the edge where reserveEn=1.
- rOut latency: 1 cycle.
- wrConflict: high exactly one cycle after the colliding edge.
- No handshake; every input is sampled every edge.

## Test plan
- Reset, then mode 1 writing 18 to R8; next cycle readAddA=8 -> readDataA=18, raDataOut=0, rOut=18 one cycle after dbgAdd=8.
- Mode 2, writeAdd=5, writeData=0xAAAA0001, highData=0xBBBB0002 -> R4=0xAAAA0001, R5=0xBBBB0002. Repeat with base 0 and ZERO_R0=1 -> R0 reads 0, R1=0xBBBB0002.
- Mode 3, writeAdd=31, writeData=7, raDataIn=0x400 -> R31=0x400, raDataOut=0x400, wrConflict pulses exactly one cycle.
- BYPASS=1: mode 1 writes 0x55 to R3 while readAddB=3 -> readDataB=0x55 in the same cycle. With BYPASS=0 -> old value, then 0x55 after the edge.
- Scoreboard:
  - reserve R6 -> busyA=1.
  - Write R6 -> busyA=0.
  - Simultaneous reserve+write R6 -> busy stays 1, data updated.
  - Reserve R0 -> busyA stays 0.
- Assert rst mid-sequence after several writes and reservations -> all reads, busy flags, rOut, raDataOut and wrConflict return 0 without waiting for a clock edge.
